// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed, parameterised access latency.
// Requests are accepted in IDLE only; completion is signalled by a one-cycle Ready pulse.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] RdData,
  output logic              Ready,
  output logic              Busy,
  output logic              Error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;

  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  assign mem_idx  = addr_q[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    rd_data_d = rd_data_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A conflicting strobe held over consecutive edges still yields isolated Error pulses.
        if (Read && Write) begin
          error_d = !error_q;
        end else if (Read || Write) begin
          addr_d  = Addr;
          data_d  = WrData;
          wr_d    = Write;
          count_d = CNT_INIT;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
          if (!in_range) begin
            error_d = 1'b1;
            if (!wr_q) rd_data_d = '0;
          end else if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rd_data_d = mem[mem_idx];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
    end
  end

  // RAM has no reset so its contents survive Reset.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_idx] <= data_q;
  end

  assign RdData = rd_data_q;
  assign Ready  = ready_q;
  assign Busy   = busy_q;
  assign Error  = error_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Word-addressed memory responder that services read/write requests issued by the CPU control FSM through the MAR/MDR path. It holds an internal RAM array and models a configurable access latency. It returns a one-cycle Ready pulse on completion and flags illegal or out-of-range requests. It replaces the fixed-timing RAM so the control FSM can be extended to wait on Ready instead of assuming single-cycle memory.

Parameters:
DATA_W, 32, data word width
ADDR_W, 9, address width in words
DEPTH, 512, number of implemented words; must satisfy DEPTH <= 2^ADDR_W
LATENCY, 2, clock edges from request acceptance to completion; legal range 1..15

Ports:
Clock  input  1  system clock; all state updates on posedge
Reset  input  1  asynchronous, active-high reset
Addr  input  ADDR_W  word address (driven from MAR)
WrData  input  DATA_W  write data (driven from MDR)
Read  input  1  read request strobe, sampled only in IDLE
Write  input  1  write request strobe, sampled only in IDLE
RdData  output  DATA_W  read data, registered, valid when Ready=1 for a read
Ready  output  1  one-cycle completion pulse
Busy  output  1  high while a request is in progress (WAIT state)
Error  output  1  one-cycle pulse for an illegal or out-of-range request

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, count=0.
  - RdData=0, Ready=0, Busy=0, Error=0.
  - Latched address/data/op are cleared.
  - RAM contents are not cleared.
- States: IDLE, WAIT, DONE. Outputs are registered; values below are the values after the stated edge.
- IDLE, Read XOR Write at edge N:
  - Latch Addr, WrData and op.
  - count=LATENCY-1, Busy=1, state=WAIT.
- IDLE, Read=1 and Write=1 at the same edge:
  - Error=1 for one cycle.
  - No access; state stays IDLE; Busy stays 0.
- WAIT, count!=0: count decrements, nothing else changes.
- WAIT, count==0 (this is edge N+LATENCY), perform the access:
  - Read, in range: RdData=mem[addr].
  - Write, in range: mem[addr]=latched data; RdData unchanged.
  - Ready=1, Busy=0, state=DONE.
- Out-of-range (latched addr >= DEPTH):
  - Reached at the completion edge: Ready=1 and Error=1 together.
  - Read: RdData=0.
  - Write: dropped, memory unchanged.
- DONE:
  - Next edge: Ready=0, Error=0, state=IDLE.
  - Requests in DONE are ignored.
  - The earliest next acceptance edge is N+LATENCY+2.
- Read/Write asserted in WAIT or DONE: ignored. No queuing, no effect on the in-flight request.
- The requester need not hold Read/Write, Addr or WrData after the acceptance edge.
- Between reads, RdData holds the last read result. Writes and errors never alter it, except an out-of-range read, which sets it to 0.
- Reset asserted in WAIT:
  - Aborts the request; no write is committed.
  - Ready never pulses for the aborted request.
- Ready and Error are never high for more than one consecutive cycle.
- Busy is 1 exactly for LATENCY cycles per accepted request.

Test Plan:
1. Assert Reset with random inputs toggling -> RdData=0, Ready=0, Busy=0, Error=0 immediately, before any clock edge; FSM in IDLE after release.
2. LATENCY=2: Write Addr=0x010, WrData=0xDEADBEEF accepted at edge N -> Busy=1 after N and N+1, Ready=1 only after N+2. Then Read Addr=0x010 -> RdData=0xDEADBEEF with a Ready pulse 2 edges after acceptance; Error=0 throughout.
3. In IDLE, Read=1 and Write=1 with Addr=0x010, WrData=0x12345678 -> Error pulses one cycle, Busy=0, Ready=0. A later read of 0x010 returns 0xDEADBEEF.
4. DEPTH=256, ADDR_W=9: Read Addr=0x1FF -> Ready=1 and Error=1 on the same cycle, RdData=0x00000000. Write to 0x1FF -> Ready+Error, and no in-range word changes.
5. LATENCY=3: during WAIT of a read to 0x020, pulse Write Addr=0x020, WrData=0xAAAA5555 -> ignored. The read completes on schedule with the prior contents, and mem[0x020] is unchanged.
6. Write 0x00000001 to 0x030 and complete it. Then start Write 0x00000002 to 0x030 and assert Reset during WAIT -> no Ready pulse. A read of 0x030 after reset returns 0x00000001.
